// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Accepts one command byte over a
// valid/ready handshake and runs the complete host-to-device sequence.
// The sequence is: clock inhibit, request-to-send, 11 device-clocked bits
// (start, 8 data LSB-first, odd parity, stop), and a device ACK check.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   tx_data      command byte, sampled only on accept
//   tx_valid     command request
//   tx_ready     high only while idle; accept = tx_valid && tx_ready
//   ps2_clk_in   raw PS2_CLK line level
//   ps2_data_in  raw PS2_DATA line level
//   ps2_clk_oe   1 = pull PS2_CLK low (open-drain at the top level)
//   ps2_data_oe  1 = pull PS2_DATA low (open-drain at the top level)
//   busy         transaction in progress
//   done         one-cycle pulse: device ACKed and lines returned idle
//   err          one-cycle pulse: device NACK or timeout
//
// All outputs are registered. They are computed from the next-state values,
// so they change on the same edge as the state register.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int RTS_CYCLES     = 200,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int FL_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACKCHK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizers (bit 0 = clock, bit 1 = data).
  // A stability filter on the clock only. Everything resets to the idle
  // (high) line level so that leaving reset does not create a false edge.
  // ---------------------------------------------------------------------
  logic [1:0]      sync1_reg, sync2_reg;
  logic            clk_filt_reg;
  logic [FL_W-1:0] flt_cnt_reg;
  logic            fall_reg;
  logic            clk_sync, data_sync;

  assign clk_sync  = sync2_reg[0];
  assign data_sync = sync2_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg    <= 2'b11;
      sync2_reg    <= 2'b11;
      clk_filt_reg <= 1'b1;
      flt_cnt_reg  <= '0;
      fall_reg     <= 1'b0;
    end else begin
      sync1_reg <= {ps2_data_in, ps2_clk_in};
      sync2_reg <= sync1_reg;
      fall_reg  <= 1'b0;
      // Count consecutive samples that disagree with the filtered level.
      // Any agreeing sample restarts the count, so short glitches vanish.
      if (clk_sync == clk_filt_reg) begin
        flt_cnt_reg <= '0;
      end else if (flt_cnt_reg == FL_LAST) begin
        clk_filt_reg <= clk_sync;
        flt_cnt_reg  <= '0;
        fall_reg     <= ~clk_sync;
      end else begin
        flt_cnt_reg <= flt_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [PH_W-1:0] ph_cnt_reg, ph_cnt_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic [3:0]      bit_idx_reg, bit_idx_next;
  // Frame is {stop, parity, data}. The start bit is implied by bit_idx == 0.
  logic [9:0]      frame_reg, frame_next;
  logic            ack_reg, ack_next;
  logic            timed_out;
  logic            cur_bit_next;

  logic tx_ready_reg, busy_reg, done_reg, err_reg, clk_oe_reg, data_oe_reg;

  assign tx_ready    = tx_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

  always_comb begin
    state_next   = state_reg;
    ph_cnt_next  = ph_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    bit_idx_next = bit_idx_reg;
    frame_next   = frame_reg;
    ack_next     = ack_reg;
    timed_out    = (to_cnt_reg == TO_LAST);

    case (state_reg)
      S_IDLE: begin
        if (tx_valid && tx_ready_reg) begin
          state_next   = S_INHIBIT;
          ph_cnt_next  = '0;
          bit_idx_next = 4'd0;
          frame_next   = {1'b1, ~^tx_data, tx_data};
        end
      end
      S_INHIBIT: begin
        if (ph_cnt_reg == INH_LAST) begin
          state_next  = S_RTS;
          ph_cnt_next = '0;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      S_RTS: begin
        to_cnt_next = '0;
        if (ph_cnt_reg == RTS_LAST) begin
          state_next = S_SEND;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      S_SEND: begin
        // Timeout wins over a fall arriving in the same cycle.
        if (timed_out) begin
          state_next = S_ERR;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
          if (fall_reg) begin
            if (bit_idx_reg == 4'd10) begin
              // Eleventh fall: the device drives the ACK bit now.
              state_next = S_ACKCHK;
              ack_next   = data_sync;
            end else begin
              bit_idx_next = bit_idx_reg + 4'd1;
              // Fall 1 moves from the start bit to frame[0] without
              // shifting. Later falls shift the next bit into place.
              if (bit_idx_reg != 4'd0) begin
                frame_next = {1'b1, frame_reg[9:1]};
              end
            end
          end
        end
      end
      S_ACKCHK: begin
        if (timed_out) begin
          state_next = S_ERR;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
          state_next  = ack_reg ? S_ERR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timed_out) begin
          state_next = S_ERR;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
          if (clk_filt_reg && data_sync) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    cur_bit_next = (bit_idx_next == 4'd0) ? 1'b0 : frame_next[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ph_cnt_reg   <= '0;
      to_cnt_reg   <= '0;
      bit_idx_reg  <= 4'd0;
      frame_reg    <= '1;
      ack_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ph_cnt_reg   <= ph_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      frame_reg    <= frame_next;
      ack_reg      <= ack_next;
      tx_ready_reg <= (state_next == S_IDLE);
      busy_reg     <= (state_next != S_IDLE);
      done_reg     <= (state_next == S_DONE);
      err_reg      <= (state_next == S_ERR);
      clk_oe_reg   <= (state_next == S_INHIBIT) || (state_next == S_RTS);
      data_oe_reg  <= (state_next == S_RTS) || ((state_next == S_SEND) && !cur_bit_next);
    end
  end

endmodule
